sys_ctrl_regs: RTL and testbench

// - AXI4-Lite slave holding the SYS_CTRL register file (0x0000_2000-0x0000_2FFF).
// - Sits downstream of the peripheral link on master port 0, and consumes its
//   pl_m_axil_req_t / pl_m_axil_resp_t traffic.
// - Drives core reset releases, boot address and software IRQ.
// - Provides a version ID, core status and a free-running 64-bit cycle counter.

---
 rtl/sys_ctrl_regs_pkg.sv | 71 +++++++
 rtl/sys_ctrl_regs_if.sv | 16 +
 rtl/sys_ctrl_regs.sv | 200 ++++++++++++++++++++
 tb/tb_sys_ctrl_regs.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_ctrl_regs_pkg.sv
// ----------------------------------------------------------------------------
// sys_ctrl_regs_pkg
// Shared definitions for the SYS_CTRL register block. It holds the AXI4-Lite
// request/response structs carried on the peripheral link (master port 0), the
// AXI response codes, the register offsets, the CORE_CTRL bit positions, the
// reset defaults, and two small helpers for address decode and byte strobes.
// ----------------------------------------------------------------------------
package sys_ctrl_regs_pkg;

   localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

   // Byte offsets inside the 4 KiB SYS_CTRL window
   localparam logic [11:0] SYS_CTRL_VERSION_OFFSET     = 12'h000;
   localparam logic [11:0] SYS_CTRL_SCRATCH0_OFFSET    = 12'h004;
   localparam logic [11:0] SYS_CTRL_SCRATCH1_OFFSET    = 12'h008;
   localparam logic [11:0] SYS_CTRL_BOOT_ADDR_OFFSET   = 12'h00C;
   localparam logic [11:0] SYS_CTRL_CORE_CTRL_OFFSET   = 12'h010;
   localparam logic [11:0] SYS_CTRL_CORE_STATUS_OFFSET = 12'h014;
   localparam logic [11:0] SYS_CTRL_CYCLE_LO_OFFSET    = 12'h018;
   localparam logic [11:0] SYS_CTRL_CYCLE_HI_OFFSET    = 12'h01C;
   localparam logic [11:0] SYS_CTRL_SOFT_IRQ_OFFSET    = 12'h020;

   localparam int unsigned SYS_CTRL_CORE_CTRL_E_RST_BIT = 0;
   localparam int unsigned SYS_CTRL_CORE_CTRL_P_RST_BIT = 1;

   localparam logic [31:0] SYS_CTRL_VERSION_DEFAULT   = 32'h0001_0000;
   localparam logic [31:0] SYS_CTRL_BOOT_ADDR_DEFAULT = 32'h0900_0000;
   // E-core is released from reset by default; the P-core waits for software
   localparam logic [1:0]  SYS_CTRL_CORE_CTRL_RST     = 2'b01;

   typedef struct packed {
      logic [31:0] aw_addr;
      logic        aw_valid;
      logic [31:0] w_data;
      logic [3:0]  w_strb;
      logic        w_valid;
      logic        b_ready;
      logic [31:0] ar_addr;
      logic        ar_valid;
      logic        r_ready;
   } pl_m_axil_req_t;

   typedef struct packed {
      logic        aw_ready;
      logic        w_ready;
      logic        b_valid;
      logic [1:0]  b_resp;
      logic        ar_ready;
      logic        r_valid;
      logic [31:0] r_data;
      logic [1:0]  r_resp;
   } pl_m_axil_resp_t;

   // Offsets are always word aligned, so every offset up to SOFT_IRQ is mapped
   function automatic logic sys_ctrl_is_mapped(input logic [11:0] off);
      return (off <= SYS_CTRL_SOFT_IRQ_OFFSET);
   endfunction

   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/sys_ctrl_regs_if.sv
// ----------------------------------------------------------------------------
// sys_ctrl_regs_if
// AXI4-Lite link between the peripheral link master port and SYS_CTRL.
//   req  : AW / W / B-ready / AR / R-ready  (master -> slave)
//   resp : AW/W/AR ready, B and R channels  (slave -> master)
// ----------------------------------------------------------------------------
interface sys_ctrl_regs_if;
   import sys_ctrl_regs_pkg::*;

   pl_m_axil_req_t  req;
   pl_m_axil_resp_t resp;

   modport master (output req, input  resp);
   modport slave  (input  req, output resp);

endinterface

// File: rtl/sys_ctrl_regs.sv
// ----------------------------------------------------------------------------
// sys_ctrl_regs
// AXI4-Lite slave for the SYS_CTRL register file (0x0000_2000-0x0000_2FFF).
// Drives the core reset releases, the boot address and the software IRQ.
// Provides a version ID, core status and a free-running 64-bit cycle counter.
//
// Ports
//   clk_i            in   system clock
//   rst_ni           in   asynchronous active-low reset
//   axil             slave AXI4-Lite request/response bundle
//   e_core_halted_i  in   E-core halted status
//   p_core_halted_i  in   P-core halted status
//   e_core_rst_no    out  E-core reset, active low (CORE_CTRL[0])
//   p_core_rst_no    out  P-core reset, active low (CORE_CTRL[1])
//   boot_addr_o      out  BOOT_ADDR register
//   soft_irq_o       out  SOFT_IRQ[0]
// ----------------------------------------------------------------------------
module sys_ctrl_regs
   import sys_ctrl_regs_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR     = 32'h0000_2000,
   parameter logic [31:0] BOOT_ADDR_RST = SYS_CTRL_BOOT_ADDR_DEFAULT,
   parameter logic [31:0] VERSION       = SYS_CTRL_VERSION_DEFAULT
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   sys_ctrl_regs_if.slave axil,
   input  logic           e_core_halted_i,
   input  logic           p_core_halted_i,
   output logic           e_core_rst_no,
   output logic           p_core_rst_no,
   output logic [31:0]    boot_addr_o,
   output logic           soft_irq_o
);

   logic            w_aw_hs;
   logic            w_w_hs;
   logic            w_ar_hs;
   logic            w_commit;
   logic [11:0]     w_ar_off;
   logic [31:0]     w_rd_data;
   logic [1:0]      w_rd_resp;
   pl_m_axil_resp_t w_resp;
   logic            w_unused;

   logic            r_aw_held;
   logic [11:0]     r_aw_off;
   logic            r_w_held;
   logic [31:0]     r_w_data;
   logic [3:0]      r_w_strb;
   logic            r_b_valid;
   logic [1:0]      r_b_resp;
   logic            r_r_valid;
   logic [31:0]     r_r_data;
   logic [1:0]      r_r_resp;

   logic [31:0]     r_scratch0;
   logic [31:0]     r_scratch1;
   logic [31:0]     r_boot_addr;
   logic [1:0]      r_core_ctrl;
   logic            r_soft_irq;
   logic [63:0]     r_cycle_cnt;
   logic [31:0]     r_cycle_hi_shadow;

   // The window base is resolved by the interconnect; only the word offset
   // inside the 4 KiB window is examined here.
   assign w_unused = ^{BASE_ADDR,
                       axil.req.aw_addr[31:12], axil.req.aw_addr[1:0],
                       axil.req.ar_addr[31:12], axil.req.ar_addr[1:0]};

   assign w_aw_hs  = axil.req.aw_valid & ~r_aw_held;
   assign w_w_hs   = axil.req.w_valid  & ~r_w_held;
   assign w_ar_hs  = axil.req.ar_valid & ~r_r_valid;
   assign w_commit = r_aw_held & r_w_held & ~r_b_valid;
   assign w_ar_off = {axil.req.ar_addr[11:2], 2'b00};

   // AW and W land in independent one-entry holds; a commit frees both
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_aw_held <= 1'b0;
         r_aw_off  <= '0;
         r_w_held  <= 1'b0;
         r_w_data  <= '0;
         r_w_strb  <= '0;
         r_b_valid <= 1'b0;
         r_b_resp  <= AXIL_RESP_OKAY;
      end else begin
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_aw_off  <= {axil.req.aw_addr[11:2], 2'b00};
         end else if (w_commit) begin
            r_aw_held <= 1'b0;
         end

         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_w_data <= axil.req.w_data;
            r_w_strb <= axil.req.w_strb;
         end else if (w_commit) begin
            r_w_held <= 1'b0;
         end

         if (w_commit) begin
            r_b_valid <= 1'b1;
            r_b_resp  <= sys_ctrl_is_mapped(r_aw_off) ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
         end else if (r_b_valid && axil.req.b_ready) begin
            r_b_valid <= 1'b0;
         end
      end
   end

   // Register file updates; RO and unmapped offsets fall through untouched
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_scratch0  <= '0;
         r_scratch1  <= '0;
         r_boot_addr <= BOOT_ADDR_RST;
         r_core_ctrl <= SYS_CTRL_CORE_CTRL_RST;
         r_soft_irq  <= 1'b0;
      end else if (w_commit) begin
         case (r_aw_off)
            SYS_CTRL_SCRATCH0_OFFSET:  r_scratch0  <= apply_wstrb(r_scratch0, r_w_data, r_w_strb);
            SYS_CTRL_SCRATCH1_OFFSET:  r_scratch1  <= apply_wstrb(r_scratch1, r_w_data, r_w_strb);
            SYS_CTRL_BOOT_ADDR_OFFSET: r_boot_addr <= apply_wstrb(r_boot_addr, r_w_data, r_w_strb);
            SYS_CTRL_CORE_CTRL_OFFSET: begin
               if (r_w_strb[0]) r_core_ctrl <= r_w_data[1:0];
            end
            SYS_CTRL_SOFT_IRQ_OFFSET: begin
               if (r_w_strb[0]) r_soft_irq <= r_w_data[0];
            end
            default: ;
         endcase
      end
   end

   // Read mux sees register state before any same-cycle commit lands
   always_comb begin
      w_rd_data = '0;
      w_rd_resp = AXIL_RESP_OKAY;
      case (w_ar_off)
         SYS_CTRL_VERSION_OFFSET:     w_rd_data = VERSION;
         SYS_CTRL_SCRATCH0_OFFSET:    w_rd_data = r_scratch0;
         SYS_CTRL_SCRATCH1_OFFSET:    w_rd_data = r_scratch1;
         SYS_CTRL_BOOT_ADDR_OFFSET:   w_rd_data = r_boot_addr;
         SYS_CTRL_CORE_CTRL_OFFSET:   w_rd_data = {30'b0, r_core_ctrl};
         SYS_CTRL_CORE_STATUS_OFFSET: w_rd_data = {30'b0, p_core_halted_i, e_core_halted_i};
         SYS_CTRL_CYCLE_LO_OFFSET:    w_rd_data = r_cycle_cnt[31:0];
         SYS_CTRL_CYCLE_HI_OFFSET:    w_rd_data = r_cycle_hi_shadow;
         SYS_CTRL_SOFT_IRQ_OFFSET:    w_rd_data = {31'b0, r_soft_irq};
         default:                     w_rd_resp = AXIL_RESP_SLVERR;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_r_valid <= 1'b0;
         r_r_data  <= '0;
         r_r_resp  <= AXIL_RESP_OKAY;
      end else if (w_ar_hs) begin
         r_r_valid <= 1'b1;
         r_r_data  <= w_rd_data;
         r_r_resp  <= w_rd_resp;
      end else if (r_r_valid && axil.req.r_ready) begin
         r_r_valid <= 1'b0;
      end
   end

   // A LO read freezes the upper word so a later HI read pairs with it even
   // if the low word has wrapped in between.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cycle_cnt       <= '0;
         r_cycle_hi_shadow <= '0;
      end else begin
         r_cycle_cnt <= r_cycle_cnt + 64'd1;
         if (w_ar_hs && (w_ar_off == SYS_CTRL_CYCLE_LO_OFFSET)) begin
            r_cycle_hi_shadow <= r_cycle_cnt[63:32];
         end
      end
   end

   always_comb begin
      w_resp          = '0;
      w_resp.aw_ready = ~r_aw_held;
      w_resp.w_ready  = ~r_w_held;
      w_resp.b_valid  = r_b_valid;
      w_resp.b_resp   = r_b_resp;
      w_resp.ar_ready = ~r_r_valid;
      w_resp.r_valid  = r_r_valid;
      w_resp.r_data   = r_r_data;
      w_resp.r_resp   = r_r_resp;
   end

   assign axil.resp     = w_resp;
   assign e_core_rst_no = r_core_ctrl[SYS_CTRL_CORE_CTRL_E_RST_BIT];
   assign p_core_rst_no = r_core_ctrl[SYS_CTRL_CORE_CTRL_P_RST_BIT];
   assign boot_addr_o   = r_boot_addr;
   assign soft_irq_o    = r_soft_irq;

endmodule

// File: tb/tb_sys_ctrl_regs.sv
// ----------------------------------------------------------------------------
// tb_sys_ctrl_regs
// Self-checking bench for sys_ctrl_regs: a table of write/read vectors with
// hand-computed results, followed by directed multi-cycle sequences.
// ----------------------------------------------------------------------------
module tb_sys_ctrl_regs;
   import sys_ctrl_regs_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        e_core_halted_i = 1'b0;
   logic        p_core_halted_i = 1'b0;
   logic        e_core_rst_no;
   logic        p_core_rst_no;
   logic [31:0] boot_addr_o;
   logic        soft_irq_o;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk_i = ~clk_i;

   sys_ctrl_regs_if axil ();

   sys_ctrl_regs dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .axil            (axil),
      .e_core_halted_i (e_core_halted_i),
      .p_core_halted_i (p_core_halted_i),
      .e_core_rst_no   (e_core_rst_no),
      .p_core_rst_no   (p_core_rst_no),
      .boot_addr_o     (boot_addr_o),
      .soft_irq_o      (soft_irq_o)
   );

   typedef struct {
      string       name;
      logic        do_wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [1:0]  bresp;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic        irq;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string name, input logic do_wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input logic [1:0] bresp, input logic [31:0] rdata,
                               input logic [1:0] rresp, input logic irq);
      vec_t v;
      v.name = name; v.do_wr = do_wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
      v.bresp = bresp; v.rdata = rdata; v.rresp = rresp; v.irq = irq;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      bit aw_done;
      bit w_done;
      int n;
      aw_done = 0; w_done = 0; n = 0; resp = 2'bxx;
      @(negedge clk_i);
      axil.req.aw_addr  = addr;
      axil.req.aw_valid = 1'b1;
      axil.req.w_data   = data;
      axil.req.w_strb   = strb;
      axil.req.w_valid  = 1'b1;
      axil.req.b_ready  = 1'b1;
      while (!(aw_done && w_done) && n < 20) begin
         if (axil.req.aw_valid && axil.resp.aw_ready) aw_done = 1;
         if (axil.req.w_valid && axil.resp.w_ready) w_done = 1;
         @(negedge clk_i);
         n++;
         if (aw_done) axil.req.aw_valid = 1'b0;
         if (w_done) axil.req.w_valid = 1'b0;
      end
      while (!axil.resp.b_valid && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      chk("wr_handshake", 64'(n < 20), 64'd1);
      resp = axil.resp.b_resp;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      int n;
      n = 0;
      @(negedge clk_i);
      axil.req.ar_addr  = addr;
      axil.req.ar_valid = 1'b1;
      axil.req.r_ready  = 1'b1;
      while (!axil.resp.ar_ready && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      @(negedge clk_i);
      axil.req.ar_valid = 1'b0;
      while (!axil.resp.r_valid && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      chk("rd_handshake", 64'(n < 20), 64'd1);
      data = axil.resp.r_data;
      resp = axil.resp.r_resp;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]  bresp;
      logic [1:0]  rresp;
      logic [31:0] rdata;
      logic [31:0] lo;
      int          nb;
      bit          stable;

      axil.req = '0;

      vecs.push_back(mk("rd_version",   0, 32'h2000, 32'h0, 4'h0, AXIL_RESP_OKAY,   32'h0001_0000, AXIL_RESP_OKAY,   0));
      vecs.push_back(mk("rd_cycle_hi0", 0, 32'h201C, 32'h0, 4'h0, AXIL_RESP_OKAY,   32'h0000_0000, AXIL_RESP_OKAY,   0));
      vecs.push_back(mk("rd_status0",   0, 32'h2014, 32'h0, 4'h0, AXIL_RESP_OKAY,   32'h0000_0000, AXIL_RESP_OKAY,   0));
      vecs.push_back(mk("rd_boot_rst",  0, 32'h200C, 32'h0, 4'h0, AXIL_RESP_OKAY,   32'h0900_0000, AXIL_RESP_OKAY,   0));
      vecs.push_back(mk("rd_core_rst",  0, 32'h2010, 32'h0, 4'h0, AXIL_RESP_OKAY,   32'h0000_0001, AXIL_RESP_OKAY,   0));
      vecs.push_back(mk("rd_scr0_rst",  0, 32'h2004, 32'h0, 4'h0, AXIL_RESP_OKAY,   32'h0000_0000, AXIL_RESP_OKAY,   0));
      vecs.push_back(mk("scr1_full",    1, 32'h2008, 32'hDEAD_BEEF, 4'hF, AXIL_RESP_OKAY, 32'hDEAD_BEEF, AXIL_RESP_OKAY, 0));
      vecs.push_back(mk("scr1_strb",    1, 32'h2008, 32'h1122_3344, 4'hA, AXIL_RESP_OKAY, 32'h11AD_33EF, AXIL_RESP_OKAY, 0));
      vecs.push_back(mk("boot_wr",      1, 32'h200C, 32'h8000_0000, 4'hF, AXIL_RESP_OKAY, 32'h8000_0000, AXIL_RESP_OKAY, 0));
      vecs.push_back(mk("version_ro",   1, 32'h2000, 32'hFFFF_FFFF, 4'hF, AXIL_RESP_OKAY, 32'h0001_0000, AXIL_RESP_OKAY, 0));
      vecs.push_back(mk("irq_set",      1, 32'h2020, 32'hFFFF_FFFF, 4'hF, AXIL_RESP_OKAY, 32'h0000_0001, AXIL_RESP_OKAY, 1));
      vecs.push_back(mk("irq_clr_ua",   1, 32'h2023, 32'h0000_0000, 4'hF, AXIL_RESP_OKAY, 32'h0000_0000, AXIL_RESP_OKAY, 0));
      vecs.push_back(mk("unmap_24",     1, 32'h2024, 32'h0000_1234, 4'hF, AXIL_RESP_SLVERR, 32'h0, AXIL_RESP_SLVERR, 0));
      vecs.push_back(mk("unmap_rd100",  0, 32'h2100, 32'h0, 4'h0, AXIL_RESP_OKAY,   32'h0000_0000, AXIL_RESP_SLVERR, 0));
      vecs.push_back(mk("unmap_ffc",    1, 32'h2FFC, 32'hCAFE_F00D, 4'hF, AXIL_RESP_SLVERR, 32'h0, AXIL_RESP_SLVERR, 0));
      vecs.push_back(mk("core_hold",    1, 32'h2010, 32'hFFFF_FFFC, 4'hF, AXIL_RESP_OKAY, 32'h0000_0000, AXIL_RESP_OKAY, 0));
      vecs.push_back(mk("irq_nostrb",   1, 32'h2020, 32'h0000_0001, 4'h0, AXIL_RESP_OKAY, 32'h0000_0000, AXIL_RESP_OKAY, 0));

      // Reset state
      repeat (2) @(negedge clk_i);
      chk("rst_aw_ready", axil.resp.aw_ready, 1);
      chk("rst_w_ready",  axil.resp.w_ready, 1);
      chk("rst_ar_ready", axil.resp.ar_ready, 1);
      chk("rst_b_valid",  axil.resp.b_valid, 0);
      chk("rst_r_valid",  axil.resp.r_valid, 0);
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("rst_boot_addr", boot_addr_o, 32'h0900_0000);
      chk("rst_e_rst_n",   e_core_rst_no, 1);
      chk("rst_p_rst_n",   p_core_rst_no, 0);
      chk("rst_soft_irq",  soft_irq_o, 0);

      // Table-driven register accesses
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].do_wr) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, bresp);
            chk($sformatf("%s_bresp", vecs[i].name), bresp, vecs[i].bresp);
         end
         axi_read(vecs[i].addr, rdata, rresp);
         chk($sformatf("%s_rdata", vecs[i].name), rdata, vecs[i].rdata);
         chk($sformatf("%s_rresp", vecs[i].name), rresp, vecs[i].rresp);
         chk($sformatf("%s_irq", vecs[i].name), soft_irq_o, vecs[i].irq);
      end
      chk("tbl_boot_addr_o", boot_addr_o, 32'h8000_0000);
      chk("tbl_e_rst_n", e_core_rst_no, 0);
      chk("tbl_p_rst_n", p_core_rst_no, 0);

      // Core release: reset outputs update with the B response
      axi_write(32'h2010, 32'h0000_0003, 4'hF, bresp);
      chk("core_rel_bresp", bresp, AXIL_RESP_OKAY);
      chk("core_rel_p_rst_n", p_core_rst_no, 1);
      chk("core_rel_e_rst_n", e_core_rst_no, 1);
      p_core_halted_i = 1'b1;
      axi_read(32'h2014, rdata, rresp);
      chk("status_p_halted", rdata, 32'h2);
      p_core_halted_i = 1'b0;
      e_core_halted_i = 1'b1;
      axi_read(32'h2014, rdata, rresp);
      chk("status_e_halted", rdata, 32'h1);
      e_core_halted_i = 1'b0;

      // W two cycles ahead of AW
      @(negedge clk_i);
      axil.req.w_data  = 32'hA5A5_5A5A;
      axil.req.w_strb  = 4'b0011;
      axil.req.w_valid = 1'b1;
      chk("wfirst_w_ready", axil.resp.w_ready, 1);
      @(negedge clk_i);
      axil.req.w_valid = 1'b0;
      chk("wfirst_w_held", axil.resp.w_ready, 0);
      chk("wfirst_no_b", axil.resp.b_valid, 0);
      @(negedge clk_i);
      axil.req.aw_addr  = 32'h2004;
      axil.req.aw_valid = 1'b1;
      chk("wfirst_aw_ready", axil.resp.aw_ready, 1);
      @(negedge clk_i);
      axil.req.aw_valid = 1'b0;
      nb = 0;
      bresp = 2'bxx;
      repeat (6) begin
         @(negedge clk_i);
         if (axil.resp.b_valid) begin
            nb++;
            bresp = axil.resp.b_resp;
         end
      end
      chk("wfirst_b_count", nb, 1);
      chk("wfirst_bresp", bresp, AXIL_RESP_OKAY);
      axi_read(32'h2004, rdata, rresp);
      chk("wfirst_scr0", rdata, 32'h0000_5A5A);

      // B backpressure: second write captured, commit waits for B handshake
      @(negedge clk_i);
      axil.req.b_ready  = 1'b0;
      axil.req.aw_addr  = 32'h2004;
      axil.req.aw_valid = 1'b1;
      axil.req.w_data   = 32'h1111_1111;
      axil.req.w_strb   = 4'hF;
      axil.req.w_valid  = 1'b1;
      @(negedge clk_i);
      axil.req.aw_valid = 1'b0;
      axil.req.w_valid  = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("bp_b_pending", axil.resp.b_valid, 1);
      axil.req.aw_addr  = 32'h2008;
      axil.req.aw_valid = 1'b1;
      axil.req.w_data   = 32'h2222_2222;
      axil.req.w_valid  = 1'b1;
      chk("bp_aw_ready2", axil.resp.aw_ready, 1);
      @(negedge clk_i);
      axil.req.aw_valid = 1'b0;
      axil.req.w_valid  = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("bp_aw_held", axil.resp.aw_ready, 0);
      chk("bp_w_held", axil.resp.w_ready, 0);
      chk("bp_b_still", axil.resp.b_valid, 1);
      axi_read(32'h2008, rdata, rresp);
      chk("bp_not_committed", rdata, 32'h11AD_33EF);
      axil.req.b_ready = 1'b1;
      nb = 0;
      for (int i = 0; i < 7; i++) begin
         if (axil.resp.b_valid) nb++;
         @(negedge clk_i);
      end
      chk("bp_b_count", nb, 2);
      axi_read(32'h2008, rdata, rresp);
      chk("bp_scr1_after", rdata, 32'h2222_2222);
      axi_read(32'h2004, rdata, rresp);
      chk("bp_scr0_after", rdata, 32'h1111_1111);

      // Commit and read of the same register in one cycle returns the old value
      @(negedge clk_i);
      axil.req.aw_addr  = 32'h2004;
      axil.req.aw_valid = 1'b1;
      axil.req.w_data   = 32'h3333_3333;
      axil.req.w_strb   = 4'hF;
      axil.req.w_valid  = 1'b1;
      @(negedge clk_i);
      axil.req.aw_valid = 1'b0;
      axil.req.w_valid  = 1'b0;
      axil.req.ar_addr  = 32'h2004;
      axil.req.ar_valid = 1'b1;
      axil.req.r_ready  = 1'b1;
      @(negedge clk_i);
      axil.req.ar_valid = 1'b0;
      chk("coll_r_valid", axil.resp.r_valid, 1);
      chk("coll_old_data", axil.resp.r_data, 32'h1111_1111);
      axi_read(32'h2004, rdata, rresp);
      chk("coll_new_data", rdata, 32'h3333_3333);

      // R backpressure
      @(negedge clk_i);
      axil.req.r_ready  = 1'b0;
      axil.req.ar_addr  = 32'h200C;
      axil.req.ar_valid = 1'b1;
      @(negedge clk_i);
      axil.req.ar_valid = 1'b0;
      stable = 1;
      repeat (5) begin
         if (!(axil.resp.r_valid === 1'b1 && axil.resp.r_data === 32'h8000_0000 &&
               axil.resp.ar_ready === 1'b0 && axil.resp.r_resp === AXIL_RESP_OKAY)) stable = 0;
         @(negedge clk_i);
      end
      chk("rbp_stable", stable, 1);
      axil.req.r_ready = 1'b1;
      @(negedge clk_i);
      chk("rbp_released", axil.resp.r_valid, 0);

      // Cycle counter: LO read just before the low word wraps
      force dut.r_cycle_cnt = 64'h0000_0000_FFFF_FFFE;
      axil.req.ar_addr  = 32'h2018;
      axil.req.ar_valid = 1'b1;
      #1 release dut.r_cycle_cnt;
      @(negedge clk_i);
      axil.req.ar_valid = 1'b0;
      chk("cyc_lo_valid", axil.resp.r_valid, 1);
      lo = axil.resp.r_data;
      chk("cyc_lo", lo, 32'hFFFF_FFFE);
      axi_read(32'h201C, rdata, rresp);
      chk("cyc_hi_shadow", rdata, 32'h0);
      axi_read(32'h2018, rdata, rresp);
      axi_read(32'h201C, rdata, rresp);
      chk("cyc_hi_after_wrap", rdata, 32'h1);

      // Reset with AW held and no W yet
      @(negedge clk_i);
      axil.req.aw_addr  = 32'h2004;
      axil.req.aw_valid = 1'b1;
      @(negedge clk_i);
      axil.req.aw_valid = 1'b0;
      chk("rstw_aw_held", axil.resp.aw_ready, 0);
      rst_ni = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      chk("rstw_aw_ready", axil.resp.aw_ready, 1);
      chk("rstw_boot", boot_addr_o, 32'h0900_0000);
      chk("rstw_p_rst_n", p_core_rst_no, 0);
      @(negedge clk_i);
      axil.req.w_data  = 32'hFFFF_FFFF;
      axil.req.w_strb  = 4'hF;
      axil.req.w_valid = 1'b1;
      @(negedge clk_i);
      axil.req.w_valid = 1'b0;
      nb = 0;
      repeat (5) begin
         @(negedge clk_i);
         if (axil.resp.b_valid) nb++;
      end
      chk("rstw_no_b", nb, 0);
      axi_read(32'h2004, rdata, rresp);
      chk("rstw_scr0", rdata, 32'h0);
      axi_read(32'h201C, rdata, rresp);
      chk("rstw_hi_cleared", rdata, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
